// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the KGP-RISC fetch front end: opcode field, HALT encoding,
// default PC step and fetch FSM state encodings.
package instr_fetch_unit_pkg;

    localparam logic [5:0] OPC_HALT    = 6'b111111;
    localparam int         OPC_MSB     = 31;
    localparam int         OPC_LSB     = 26;
    localparam int         DEF_PC_STEP = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_HOLD  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HALT  = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_fetch_pc_reg.sv
// Program counter register: reset load, sequential increment and word-aligned redirect load.
module fetch_pc_reg
    import instr_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = DEF_PC_STEP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_pc_i,
    input  logic              incr_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Redirect wins over increment; low two bits are cleared so targets stay word aligned.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_pc_i & ~ADDR_W'(2'b11);
        end else if (incr_i) begin
            pc_d = pc_q + ADDR_W'(PC_STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch FSM, instruction register and accept counter; requests words
// from imem over req/ack and presents them downstream over valid/ready.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = DEF_PC_STEP
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [5:0]        opcode,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted,
    output logic [31:0]       fetch_count
);

    fetch_state_e      state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0] drain_addr_q, drain_addr_d;
    logic [ADDR_W-1:0] pc;
    logic              pc_load;
    logic              pc_incr;

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc (
        .clk       (clk),
        .rst       (rst),
        .load_i    (pc_load),
        .load_pc_i (redirect_pc),
        .incr_i    (pc_incr),
        .pc_o      (pc)
    );

    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        ipc_d        = ipc_q;
        cnt_d        = cnt_q;
        drain_addr_d = drain_addr_q;
        pc_load      = 1'b0;
        pc_incr      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                pc_load = redirect_valid;
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (redirect_valid) begin
                    // A same-cycle ack completes the old request, so no drain is needed.
                    pc_load      = 1'b1;
                    drain_addr_d = pc;
                    state_d      = imem_ack ? ST_FETCH : ST_DRAIN;
                end else if (imem_ack) begin
                    ir_d    = imem_rdata;
                    ipc_d   = pc;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (instr_ready) begin
                    cnt_d = cnt_q + 32'd1;
                end
                if (redirect_valid) begin
                    pc_load = 1'b1;
                    state_d = ST_FETCH;
                end else if (instr_ready) begin
                    if (ir_q[OPC_MSB:OPC_LSB] == OPC_HALT) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_incr = 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DRAIN: begin
                pc_load = redirect_valid;
                if (imem_ack) begin
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: begin
                if (redirect_valid) begin
                    pc_load = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
            ipc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            ipc_q   <= ipc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Address of the abandoned request; only meaningful while draining.
    always_ff @(posedge clk) begin
        drain_addr_q <= drain_addr_d;
    end

    assign imem_req    = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    assign imem_addr   = (state_q == ST_FETCH) ? pc :
                         (state_q == ST_DRAIN) ? drain_addr_q : '0;
    assign instr_valid = (state_q == ST_HOLD);
    assign halted      = (state_q == ST_HALT);
    assign instr       = ir_q;
    assign opcode      = ir_q[OPC_MSB:OPC_LSB];
    assign instr_pc    = ipc_q;
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;
    logic [31:0] fetch_count;

    int nvec  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .opcode         (opcode),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    typedef struct {
        logic        rst;
        logic        ack;
        logic [31:0] rdata;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
        logic        e_halt;
        logic [31:0] e_cnt;
    } vec_t;

    localparam logic [31:0] A0 = 32'h0000_0011, A1 = 32'h0400_0022, A2 = 32'h0800_0033;
    localparam logic [31:0] A3 = 32'h0C00_0044, A4 = 32'h1000_0055, A5 = 32'h1400_0066;
    localparam logic [31:0] A6 = 32'h1800_0077, HW = 32'hFC00_0000;
    localparam logic [31:0] DEAD = 32'hDEAD_BEEF, BAD = 32'hFFFF_FFFF;

    function automatic vec_t mk(input logic r, input logic ack, input logic [31:0] rdata,
                                input logic rdy, input logic rv, input logic [31:0] rpc,
                                input logic req, input logic [31:0] addr, input logic vld,
                                input logic [31:0] ins, input logic [31:0] ipc,
                                input logic hlt, input logic [31:0] cnt);
        vec_t v;
        v.rst = r; v.ack = ack; v.rdata = rdata; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.e_req = req; v.e_addr = addr; v.e_vld = vld; v.e_instr = ins; v.e_ipc = ipc;
        v.e_halt = hlt; v.e_cnt = cnt;
        return v;
    endfunction

    // Drive one cycle of inputs after the falling edge, then compare the registered outputs.
    task automatic apply(input vec_t v, input string name);
        logic [5:0] e_op;
        @(negedge clk);
        rst = v.rst; imem_ack = v.ack; imem_rdata = v.rdata; instr_ready = v.rdy;
        redirect_valid = v.rv; redirect_pc = v.rpc;
        #1;
        e_op = v.e_instr[31:26];
        nvec++;
        if (imem_req !== v.e_req || imem_addr !== v.e_addr || instr_valid !== v.e_vld ||
            instr !== v.e_instr || opcode !== e_op || instr_pc !== v.e_ipc ||
            halted !== v.e_halt || fetch_count !== v.e_cnt) begin
            nfail++;
            $display("FAIL %s: got req=%0b addr=%h vld=%0b instr=%h op=%h ipc=%h halt=%0b cnt=%0d | want req=%0b addr=%h vld=%0b instr=%h op=%h ipc=%h halt=%0b cnt=%0d",
                     name, imem_req, imem_addr, instr_valid, instr, opcode, instr_pc, halted, fetch_count,
                     v.e_req, v.e_addr, v.e_vld, v.e_instr, e_op, v.e_ipc, v.e_halt, v.e_cnt);
        end
    endtask

    vec_t tbl[17];

    initial begin
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;

        //             rst ack rdata rdy rv rpc        | req addr        vld instr ipc        hlt cnt
        tbl[0]  = mk(1, 0, 0,    0, 0, 0,           0, 32'h0,       0, 0,  32'h0,     0, 0);
        tbl[1]  = mk(0, 0, 0,    0, 0, 0,           0, 32'h0,       0, 0,  32'h0,     0, 0);
        tbl[2]  = mk(0, 1, A0,   1, 0, 0,           1, 32'h0,       0, 0,  32'h0,     0, 0);
        tbl[3]  = mk(0, 0, 0,    1, 0, 0,           0, 32'h0,       1, A0, 32'h0,     0, 0);
        tbl[4]  = mk(0, 1, A1,   1, 0, 0,           1, 32'h4,       0, A0, 32'h0,     0, 1);
        tbl[5]  = mk(0, 0, 0,    1, 0, 0,           0, 32'h0,       1, A1, 32'h4,     0, 1);
        tbl[6]  = mk(0, 1, A2,   1, 0, 0,           1, 32'h8,       0, A1, 32'h4,     0, 2);
        tbl[7]  = mk(0, 0, 0,    1, 0, 0,           0, 32'h0,       1, A2, 32'h8,     0, 2);
        tbl[8]  = mk(0, 0, 0,    0, 0, 0,           1, 32'hC,       0, A2, 32'h8,     0, 3);
        tbl[9]  = mk(0, 0, 0,    0, 1, 32'h103,     1, 32'hC,       0, A2, 32'h8,     0, 3);
        tbl[10] = mk(0, 0, 0,    0, 0, 0,           1, 32'hC,       0, A2, 32'h8,     0, 3);
        tbl[11] = mk(0, 0, 0,    0, 0, 0,           1, 32'hC,       0, A2, 32'h8,     0, 3);
        tbl[12] = mk(0, 1, DEAD, 0, 0, 0,           1, 32'hC,       0, A2, 32'h8,     0, 3);
        tbl[13] = mk(0, 1, A3,   0, 0, 0,           1, 32'h100,     0, A2, 32'h8,     0, 3);
        tbl[14] = mk(0, 0, 0,    1, 1, 32'h200,     0, 32'h0,       1, A3, 32'h100,   0, 3);
        tbl[15] = mk(0, 1, A4,   0, 0, 0,           1, 32'h200,     0, A3, 32'h100,   0, 4);
        tbl[16] = mk(0, 0, 0,    0, 0, 0,           0, 32'h0,       1, A4, 32'h200,   0, 4);

        repeat (2) @(posedge clk);
        for (int i = 0; i < 17; i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Decoder stalls in HOLD: everything stays put and no request is issued.
        for (int i = 0; i < 5; i++) begin
            apply(mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 1, A4, 32'h200, 0, 4), $sformatf("stall%0d", i));
        end
        apply(mk(0, 0, 0, 1, 0, 0, 0, 32'h0, 1, A4, 32'h200, 0, 4), "stall_accept");
        apply(mk(0, 0, 0, 0, 0, 0, 1, 32'h204, 0, A4, 32'h200, 0, 5), "after_stall_addr");

        // Redirect with ack in the same FETCH cycle drops the word; HALT word with redirect is not a halt.
        apply(mk(0, 1, BAD, 0, 1, 32'h300, 1, 32'h204, 0, A4, 32'h200, 0, 5), "fetch_redir_ack");
        apply(mk(0, 1, HW, 0, 0, 0, 1, 32'h300, 0, A4, 32'h200, 0, 5), "fetch_after_drop");
        apply(mk(0, 0, 0, 1, 1, 32'h400, 0, 32'h0, 1, HW, 32'h300, 0, 5), "halt_with_redir");
        apply(mk(0, 1, HW, 0, 0, 0, 1, 32'h400, 0, HW, 32'h300, 0, 6), "fetch_halt_word");
        apply(mk(0, 0, 0, 1, 0, 0, 0, 32'h0, 1, HW, 32'h400, 0, 6), "accept_halt");
        for (int i = 0; i < 20; i++) begin
            apply(mk(0, i[0], DEAD, 1, 0, 0, 0, 32'h0, 0, HW, 32'h400, 1, 7), $sformatf("halted%0d", i));
        end
        apply(mk(0, 0, 0, 0, 1, 32'h40, 0, 32'h0, 0, HW, 32'h400, 1, 7), "halt_redirect");
        apply(mk(0, 0, 0, 0, 1, 32'hFFFF_FFFF, 1, 32'h40, 0, HW, 32'h400, 0, 7), "resume_fetch");

        // PC wrap at the top of the address space, then reset mid-fetch.
        apply(mk(0, 0, 0, 0, 1, 32'h0000_0083, 1, 32'h40, 0, HW, 32'h400, 0, 7), "drain_redir");
        apply(mk(0, 1, DEAD, 0, 1, 32'hFFFF_FFFD, 1, 32'h40, 0, HW, 32'h400, 0, 7), "drain_ack");
        apply(mk(0, 1, A5, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, HW, 32'h400, 0, 7), "fetch_top");
        apply(mk(0, 0, 0, 1, 0, 0, 0, 32'h0, 1, A5, 32'hFFFF_FFFC, 0, 7), "accept_top");
        apply(mk(0, 1, A6, 0, 0, 0, 1, 32'h0, 0, A5, 32'hFFFF_FFFC, 0, 8), "wrap_addr");
        apply(mk(0, 0, 0, 1, 0, 0, 0, 32'h0, 1, A6, 32'h0, 0, 8), "accept_wrap");
        apply(mk(1, 0, 0, 0, 0, 0, 1, 32'h4, 0, A6, 32'h0, 0, 9), "rst_in_fetch");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0), "after_rst");
        apply(mk(0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 32'h0, 0, 0), "refetch_reset_pc");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
